// File: rtl/collision_detector.sv
// Snake body tracker for the game-event side of the score path: checks each move
// against the walls and the body, then commits it and reports apple/crash pulses.
module collision_detector #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 8,
    parameter int MAX_LEN = 16,
    parameter int START_X = 4,
    parameter int START_Y = 3,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          step,
    input  logic [1:0]    dir,
    input  logic          halt,
    input  logic [XW-1:0] apple_x,
    input  logic [YW-1:0] apple_y,
    output logic          goodColl,
    output logic          badColl,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] snake_len,
    output logic          busy,
    output logic          game_over
);

    localparam int IW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {IDLE, MOVE, CHECK, UPDATE, DEAD} state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } cell_t;

    state_t        state;
    state_t        state_n;
    cell_t         body [MAX_LEN];
    cell_t         next_cell;
    cell_t         cand;
    logic [1:0]    heading;
    logic [IW-1:0] idx;
    logic [LW-1:0] len;
    logic          wall;
    logic          self_hit;
    logic          last_idx;
    logic          apple_hit;

    // Candidate head cell for the current heading; a move off the grid is a wall hit.
    always_comb begin
        cand = body[0];
        wall = 1'b0;
        case (heading)
            2'b00: begin
                if (body[0].y == '0) wall = 1'b1;
                else cand.y = body[0].y - YW'(1);
            end
            2'b01: begin
                if (body[0].x == XW'(GRID_W - 1)) wall = 1'b1;
                else cand.x = body[0].x + XW'(1);
            end
            2'b10: begin
                if (body[0].y == YW'(GRID_H - 1)) wall = 1'b1;
                else cand.y = body[0].y + YW'(1);
            end
            default: begin
                if (body[0].x == '0) wall = 1'b1;
                else cand.x = body[0].x - XW'(1);
            end
        endcase
    end

    // The tail is never compared because it vacates its cell on the same move.
    assign self_hit  = (next_cell == body[idx]);
    assign last_idx  = (LW'(idx) == len - LW'(2));
    assign apple_hit = (next_cell.x == apple_x) && (next_cell.y == apple_y);

    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (step && !halt) state_n = MOVE;
            MOVE: begin
                if (wall)                 state_n = DEAD;
                else if (len == LW'(1))   state_n = UPDATE;
                else                      state_n = CHECK;
            end
            CHECK: begin
                if (self_hit)      state_n = DEAD;
                else if (last_idx) state_n = UPDATE;
            end
            UPDATE:  state_n = IDLE;
            DEAD:    state_n = DEAD;
            default: state_n = IDLE;
        endcase
    end

    // Body, heading and the registered collision pulses.
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            for (int i = 1; i < MAX_LEN; i++) body[i] <= '0;
            body[0]   <= '{x: XW'(START_X), y: YW'(START_Y)};
            len       <= LW'(1);
            heading   <= 2'b01;
            next_cell <= '0;
            idx       <= '0;
            goodColl  <= 1'b0;
            badColl   <= 1'b0;
        end else begin
            goodColl <= 1'b0;
            badColl  <= 1'b0;
            case (state)
                IDLE: begin
                    if (step && !halt && (dir != (heading ^ 2'b10))) heading <= dir;
                end
                MOVE: begin
                    next_cell <= cand;
                    idx       <= '0;
                    if (wall) badColl <= 1'b1;
                end
                CHECK: begin
                    if (self_hit) badColl <= 1'b1;
                    else          idx <= idx + IW'(1);
                end
                UPDATE: begin
                    for (int i = MAX_LEN - 1; i > 0; i--) body[i] <= body[i-1];
                    body[0] <= next_cell;
                    if (apple_hit) begin
                        goodColl <= 1'b1;
                        if (len != LW'(MAX_LEN)) len <= len + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_x    = body[0].x;
    assign head_y    = body[0].y;
    assign snake_len = len;
    assign busy      = (state != IDLE) && (state != DEAD);
    assign game_over = (state == DEAD);

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: directed moves queue their expected
// pulse (kind, committed head/length, latency); a monitor pops on every pulse.
module tb_collision_detector;

    logic       clk = 1'b0;
    logic       nRst;
    logic       step;
    logic [1:0] dir;
    logic       halt;
    logic [3:0] apple_x;
    logic [2:0] apple_y;
    logic       goodColl;
    logic       badColl;
    logic [3:0] head_x;
    logic [2:0] head_y;
    logic [4:0] snake_len;
    logic       busy;
    logic       game_over;

    typedef struct packed {
        logic       good;
        logic       bad;
        logic [3:0] hx;
        logic [2:0] hy;
        logic [4:0] len;
        logic [7:0] lat;
    } event_t;

    event_t expq[$];
    event_t mon_act;
    event_t mon_exp;
    int     vectors     = 0;
    int     miscompares = 0;
    int     cycle_cnt   = 0;
    int     step_cycle  = 0;

    collision_detector dut (
        .clk       (clk),
        .nRst      (nRst),
        .step      (step),
        .dir       (dir),
        .halt      (halt),
        .apple_x   (apple_x),
        .apple_y   (apple_y),
        .goodColl  (goodColl),
        .badColl   (badColl),
        .head_x    (head_x),
        .head_y    (head_y),
        .snake_len (snake_len),
        .busy      (busy),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic bad, input logic [3:0] hx, input logic [2:0] hy,
                                input logic [4:0] len, input logic [7:0] lat);
        expq.push_back('{good: !bad, bad: bad, hx: hx, hy: hy, len: len, lat: lat});
    endtask

    // One move request; step stays high for 'hold' sampled edges, then wait for idle.
    task automatic apply_stimulus(input logic [1:0] d, input int hold);
        int n;
        @(negedge clk);
        dir  = d;
        step = 1'b1;
        @(posedge clk);
        #1 step_cycle = cycle_cnt;
        for (int i = 1; i < hold; i++) @(negedge clk);
        @(negedge clk);
        step = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle_timeout: busy still 1 after 40 cycles, required 0");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        nRst = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [3:0] hx, input logic [2:0] hy,
                              input logic [4:0] len);
        check_output({name, "_x"}, 32'(head_x), 32'(hx));
        check_output({name, "_y"}, 32'(head_y), 32'(hy));
        check_output({name, "_len"}, 32'(snake_len), 32'(len));
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (goodColl || badColl) begin
                mon_act = '{good: goodColl, bad: badColl, hx: head_x, hy: head_y,
                            len: snake_len, lat: 8'(cycle_cnt - step_cycle + 1)};
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL pulse: got good=%0b bad=%0b head=(%0d,%0d) len=%0d, expected no pulse",
                             goodColl, badColl, head_x, head_y, snake_len);
                end else begin
                    mon_exp = expq.pop_front();
                    if (mon_act !== mon_exp) begin
                        miscompares++;
                        $display("[TB] FAIL pulse: got good=%0b bad=%0b head=(%0d,%0d) len=%0d lat=%0d, expected good=%0b bad=%0b head=(%0d,%0d) len=%0d lat=%0d",
                                 mon_act.good, mon_act.bad, mon_act.hx, mon_act.hy, mon_act.len, mon_act.lat,
                                 mon_exp.good, mon_exp.bad, mon_exp.hx, mon_exp.hy, mon_exp.len, mon_exp.lat);
                    end
                end
            end
        end
    end

    initial begin
        nRst = 1'b1; step = 1'b0; dir = 2'b00; halt = 1'b0;
        apple_x = 4'd5; apple_y = 3'd3;
        repeat (2) @(negedge clk);
        check_head("reset", 4'd4, 3'd3, 5'd1);
        check_output("reset_flags", 32'({goodColl, badColl, busy, game_over}), 32'd0);
        nRst = 1'b0;

        // Eat three apples moving right.
        expect_pulse(1'b0, 4'd5, 3'd3, 5'd2, 8'd3);
        apply_stimulus(2'b01, 1);
        check_head("eat1", 4'd5, 3'd3, 5'd2);
        apple_x = 4'd6;
        expect_pulse(1'b0, 4'd6, 3'd3, 5'd3, 8'd4);
        apply_stimulus(2'b01, 1);
        apple_x = 4'd7;
        expect_pulse(1'b0, 4'd7, 3'd3, 5'd4, 8'd5);
        apply_stimulus(2'b01, 1);
        check_head("eat3", 4'd7, 3'd3, 5'd4);

        // Plain moves; the down move lands on the vacating tail cell (7,3).
        apple_x = 4'd0; apple_y = 3'd0;
        apply_stimulus(2'b01, 1);
        check_head("plain", 4'd8, 3'd3, 5'd4);
        apply_stimulus(2'b00, 1);
        apply_stimulus(2'b11, 1);
        apply_stimulus(2'b10, 1);
        check_head("tail_vacate", 4'd7, 3'd3, 5'd4);

        // Heading down, up requested and step held over three edges: one move down.
        apply_stimulus(2'b00, 3);
        check_head("reverse_hold", 4'd7, 3'd4, 5'd4);

        // Grow to five, then curl back into the body (hit at compare index 3).
        apple_x = 4'd7; apple_y = 3'd5;
        expect_pulse(1'b0, 4'd7, 3'd5, 5'd5, 8'd6);
        apply_stimulus(2'b10, 1);
        apple_x = 4'd0; apple_y = 3'd0;
        apply_stimulus(2'b01, 1);
        apply_stimulus(2'b00, 1);
        expect_pulse(1'b1, 4'd8, 3'd4, 5'd5, 8'd6);
        apply_stimulus(2'b11, 1);
        check_output("self_dead", 32'({busy, game_over}), 32'b01);

        // Dead: steps are ignored even toward an apple.
        apple_x = 4'd9; apple_y = 3'd4;
        apply_stimulus(2'b01, 1);
        apply_stimulus(2'b01, 1);
        repeat (5) @(negedge clk);
        check_head("dead_frozen", 4'd8, 3'd4, 5'd5);
        check_output("dead_flag", 32'(game_over), 32'd1);

        // Halt blocks steps.
        do_reset();
        apple_x = 4'd5; apple_y = 3'd3;
        halt = 1'b1;
        apply_stimulus(2'b01, 1);
        apply_stimulus(2'b01, 1);
        check_head("halt", 4'd4, 3'd3, 5'd1);
        check_output("halt_busy", 32'(busy), 32'd0);
        halt = 1'b0;

        // Right wall: walk to x=15, then one more step crashes.
        apple_x = 4'd0; apple_y = 3'd0;
        for (int i = 0; i < 11; i++) apply_stimulus(2'b01, 1);
        check_head("at_wall", 4'd15, 3'd3, 5'd1);
        expect_pulse(1'b1, 4'd15, 3'd3, 5'd1, 8'd2);
        apply_stimulus(2'b01, 1);
        check_output("wall_dead", 32'(game_over), 32'd1);

        // Reset asserted while the length-2 snake is in its compare pass.
        do_reset();
        apple_x = 4'd5; apple_y = 3'd3;
        expect_pulse(1'b0, 4'd5, 3'd3, 5'd2, 8'd3);
        apply_stimulus(2'b01, 1);
        apple_x = 4'd0; apple_y = 3'd0;
        @(negedge clk);
        dir = 2'b01; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check_output("mid_check_busy", 32'(busy), 32'd1);
        nRst = 1'b1;
        #1;
        check_head("mid_reset", 4'd4, 3'd3, 5'd1);
        check_output("mid_reset_flags", 32'({goodColl, badColl, busy, game_over}), 32'd0);
        @(negedge clk);
        nRst = 1'b0;
        repeat (5) @(negedge clk);

        check_output("pending_pulses", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
